// File: rtl/multi_module_status_monitor.sv
// multi_module_status_monitor
// Watches NUM_CH HLS ap_ctrl_chain interfaces in parallel. Per channel it
// tracks outstanding transactions, saturating start/done counts and
// done-to-done interval statistics, flags stalls and protocol errors, and
// raises a global deadlock flag. Statistics are read through an indexed,
// combinational readout port. Asserting finish freezes everything until reset.
//
// Handshake: a start is accepted on a rising edge where ap_start & ap_ready
// (event S); a done is consumed on a rising edge where ap_done & ap_continue
// (event D). ap_done held high with ap_continue low is downstream
// back-pressure and is not a completion.
module multi_module_status_monitor #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int OUT_W       = 4,
    parameter int STALL_LIMIT = 1024,
    localparam int RD_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  finish,
    input  logic [NUM_CH-1:0]     ap_start,
    input  logic [NUM_CH-1:0]     ap_ready,
    input  logic [NUM_CH-1:0]     ap_done,
    input  logic [NUM_CH-1:0]     ap_continue,
    output logic [2*NUM_CH-1:0]   ch_state,
    output logic [NUM_CH-1:0]     stall,
    output logic [NUM_CH-1:0]     proto_err,
    output logic                  deadlock,
    output logic                  all_idle,
    input  logic [RD_W-1:0]       rd_sel,
    output logic [CNT_W-1:0]      rd_start_cnt,
    output logic [CNT_W-1:0]      rd_done_cnt,
    output logic [CNT_W-1:0]      rd_last_ii,
    output logic [CNT_W-1:0]      rd_min_ii,
    output logic [CNT_W-1:0]      rd_max_ii,
    output logic [OUT_W-1:0]      rd_outstanding
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_WAIT = 2'd2,
        ST_STALLED   = 2'd3
    } ch_state_e;

    localparam int               NOP_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [NOP_W-1:0] NOP_MAX = NOP_W'(STALL_LIMIT);
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    // Freeze is sticky: the edge that samples finish and every later edge hold.
    logic frozen_q;
    logic frozen;
    assign frozen = finish | frozen_q;

    // Sticky freeze register, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) frozen_q <= 1'b0;
        else        frozen_q <= frozen;
    end

    // Flattened per-channel statistics feeding the readout mux.
    logic [NUM_CH*CNT_W-1:0] start_flat, done_flat, last_flat, min_flat, max_flat;
    logic [NUM_CH*OUT_W-1:0] out_flat;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_e        state_q, state_d;
        logic [OUT_W-1:0] out_q, out_d;
        logic [CNT_W-1:0] start_q, start_d, done_q, done_d;
        logic [CNT_W-1:0] tmr_q, tmr_d, tmr_inc;
        logic [CNT_W-1:0] last_q, last_d, min_q, min_d, max_q, max_d;
        logic             run_q, run_d;
        logic [NOP_W-1:0] nop_q, nop_d;
        logic             stall_q, stall_d, err_q, err_d;
        logic             s_ev, d_ev, d_ok, hold_done;

        assign s_ev      = ap_start[g] & ap_ready[g];
        assign d_ev      = ap_done[g] & ap_continue[g];
        // A done with nothing outstanding is a protocol error, not a completion.
        assign d_ok      = d_ev & (out_q != '0);
        assign hold_done = ap_done[g] & ~ap_continue[g];
        assign tmr_inc   = (tmr_q == '1) ? tmr_q : tmr_q + CNT_W'(1);

        // Counters, outstanding, interval timer and no-progress counter.
        always_comb begin
            out_d   = out_q;
            start_d = start_q;
            done_d  = done_q;
            tmr_d   = tmr_q;
            run_d   = run_q;
            last_d  = last_q;
            min_d   = min_q;
            max_d   = max_q;
            nop_d   = nop_q;
            if (!frozen) begin
                if (s_ev && start_q != '1) start_d = start_q + CNT_W'(1);
                if (d_ok && done_q != '1)  done_d  = done_q + CNT_W'(1);

                if (s_ev && !d_ok) begin
                    if (out_q != OUT_MAX) out_d = out_q + OUT_W'(1);
                end else if (!s_ev && d_ok) begin
                    out_d = out_q - OUT_W'(1);
                end

                // Timer starts at the first done; each later done closes an interval.
                if (d_ok) begin
                    run_d = 1'b1;
                    tmr_d = '0;
                    if (run_q) begin
                        last_d = tmr_inc;
                        if (tmr_inc < min_q) min_d = tmr_inc;
                        if (tmr_inc > max_q) max_d = tmr_inc;
                    end
                end else if (run_q) begin
                    tmr_d = tmr_inc;
                end

                if (state_q == ST_BUSY || state_q == ST_DONE_WAIT) begin
                    if (s_ev || d_ev)        nop_d = '0;
                    else if (nop_q != NOP_MAX) nop_d = nop_q + NOP_W'(1);
                end else if (state_q == ST_IDLE || s_ev || d_ev) begin
                    nop_d = '0;
                end
            end
        end

        // Channel FSM next state, evaluated on post-update outstanding/nop.
        always_comb begin
            state_d = state_q;
            if (!frozen) begin
                case (state_q)
                    ST_IDLE: begin
                        if (out_d != '0) state_d = ST_BUSY;
                    end
                    ST_BUSY: begin
                        if (hold_done)             state_d = ST_DONE_WAIT;
                        else if (out_d == '0)      state_d = ST_IDLE;
                        else if (nop_d == NOP_MAX) state_d = ST_STALLED;
                    end
                    ST_DONE_WAIT: begin
                        if (ap_continue[g])        state_d = (out_d == '0) ? ST_IDLE : ST_BUSY;
                        else if (nop_d == NOP_MAX) state_d = ST_STALLED;
                    end
                    ST_STALLED: begin
                        if (s_ev || d_ev)          state_d = (out_d == '0) ? ST_IDLE : ST_BUSY;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // Sticky flags: stall on entry to STALLED, proto_err on bad S/D.
        always_comb begin
            stall_d = stall_q;
            err_d   = err_q;
            if (!frozen) begin
                if (state_d == ST_STALLED && state_q != ST_STALLED) stall_d = 1'b1;
                if (d_ev && !d_ok)                                 err_d   = 1'b1;
                if (s_ev && !d_ok && out_q == OUT_MAX)             err_d   = 1'b1;
            end
        end

        // Channel FSM state register.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) state_q <= ST_IDLE;
            else        state_q <= state_d;
        end

        // Channel statistics and flag registers.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                out_q   <= '0;
                start_q <= '0;
                done_q  <= '0;
                tmr_q   <= '0;
                run_q   <= 1'b0;
                last_q  <= '0;
                min_q   <= '1;
                max_q   <= '0;
                nop_q   <= '0;
                stall_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                out_q   <= out_d;
                start_q <= start_d;
                done_q  <= done_d;
                tmr_q   <= tmr_d;
                run_q   <= run_d;
                last_q  <= last_d;
                min_q   <= min_d;
                max_q   <= max_d;
                nop_q   <= nop_d;
                stall_q <= stall_d;
                err_q   <= err_d;
            end
        end

        assign ch_state[2*g +: 2]          = state_q;
        assign stall[g]                    = stall_q;
        assign proto_err[g]                = err_q;
        assign start_flat[g*CNT_W +: CNT_W] = start_q;
        assign done_flat[g*CNT_W +: CNT_W]  = done_q;
        assign last_flat[g*CNT_W +: CNT_W]  = last_q;
        assign min_flat[g*CNT_W +: CNT_W]   = min_q;
        assign max_flat[g*CNT_W +: CNT_W]   = max_q;
        assign out_flat[g*OUT_W +: OUT_W]   = out_q;
    end

    logic any_stalled, all_quiet, none_out;

    // Global conditions over all channels' registered state.
    always_comb begin
        any_stalled = 1'b0;
        all_quiet   = 1'b1;
        none_out    = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_state[2*i +: 2] == ST_STALLED) any_stalled = 1'b1;
            if (ch_state[2*i +: 2] == ST_BUSY || ch_state[2*i +: 2] == ST_DONE_WAIT) all_quiet = 1'b0;
            if (out_flat[i*OUT_W +: OUT_W] != '0) none_out = 1'b0;
        end
    end

    logic deadlock_q, all_idle_q;

    // Sticky deadlock flag and registered all-idle indication.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deadlock_q <= 1'b0;
            all_idle_q <= 1'b1;
        end else begin
            deadlock_q <= deadlock_q | (~frozen & any_stalled & all_quiet);
            all_idle_q <= none_out;
        end
    end

    assign deadlock = deadlock_q;
    assign all_idle = all_idle_q;

    // Readout mux; an out-of-range select reads as all zeros.
    always_comb begin
        rd_start_cnt   = '0;
        rd_done_cnt    = '0;
        rd_last_ii     = '0;
        rd_min_ii      = '0;
        rd_max_ii      = '0;
        rd_outstanding = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == RD_W'(i)) begin
                rd_start_cnt   = start_flat[i*CNT_W +: CNT_W];
                rd_done_cnt    = done_flat[i*CNT_W +: CNT_W];
                rd_last_ii     = last_flat[i*CNT_W +: CNT_W];
                rd_min_ii      = min_flat[i*CNT_W +: CNT_W];
                rd_max_ii      = max_flat[i*CNT_W +: CNT_W];
                rd_outstanding = out_flat[i*OUT_W +: OUT_W];
            end
        end
    end

endmodule

// File: tb/tb_multi_module_status_monitor.sv
// Directed bench for multi_module_status_monitor (3 channels, 16-bit counters,
// 2-bit outstanding, STALL_LIMIT=16). Inputs change on the falling edge and
// outputs are observed on the falling edge, half a period from the active edge.
module tb_multi_module_status_monitor;

    localparam int NUM_CH      = 3;
    localparam int CNT_W       = 16;
    localparam int OUT_W       = 2;
    localparam int STALL_LIMIT = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                finish = 1'b0;
    logic [NUM_CH-1:0]   ap_start, ap_ready, ap_done, ap_continue;
    logic [2*NUM_CH-1:0] ch_state;
    logic [NUM_CH-1:0]   stall, proto_err;
    logic                deadlock, all_idle;
    logic [1:0]          rd_sel;
    logic [CNT_W-1:0]    rd_start_cnt, rd_done_cnt, rd_last_ii, rd_min_ii, rd_max_ii;
    logic [OUT_W-1:0]    rd_outstanding;

    int total = 0;
    int bad   = 0;
    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] got[6];
    logic [CNT_W-1:0] e;
    string rd_nm[6] = '{"start_cnt", "done_cnt", "last_ii", "min_ii", "max_ii", "outstanding"};

    multi_module_status_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .OUT_W(OUT_W), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .ch_state(ch_state), .stall(stall), .proto_err(proto_err),
        .deadlock(deadlock), .all_idle(all_idle), .rd_sel(rd_sel),
        .rd_start_cnt(rd_start_cnt), .rd_done_cnt(rd_done_cnt), .rd_last_ii(rd_last_ii),
        .rd_min_ii(rd_min_ii), .rd_max_ii(rd_max_ii), .rd_outstanding(rd_outstanding)
    );

    // Clock
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, bad=%0d", bad);
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ap_start    = '0;
        ap_ready    = '0;
        ap_done     = '0;
        ap_continue = '1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One edge with S and/or D on channel ch, then inputs return to idle.
    task automatic pulse(input int ch, input logic s, input logic d);
        ap_start[ch]    = s;
        ap_ready[ch]    = s;
        ap_done[ch]     = d;
        ap_continue[ch] = 1'b1;
        @(negedge clock);
        ap_start[ch] = 1'b0;
        ap_ready[ch] = 1'b0;
        ap_done[ch]  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rd_sel = 2'd0;
        step(2);
        total++; if (ch_state !== 6'b0) begin bad++; $display("FAIL reset_state got=%b exp=%b", ch_state, 6'b0); end
        total++; if (stall !== 3'b0) begin bad++; $display("FAIL reset_stall got=%b exp=000", stall); end
        total++; if (proto_err !== 3'b0) begin bad++; $display("FAIL reset_proto got=%b exp=000", proto_err); end
        total++; if (deadlock !== 1'b0) begin bad++; $display("FAIL reset_deadlock got=%b exp=0", deadlock); end
        total++; if (all_idle !== 1'b1) begin bad++; $display("FAIL reset_all_idle got=%b exp=1", all_idle); end
        exp_q = '{16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd0, 16'd0};
        got = '{rd_start_cnt, rd_done_cnt, rd_last_ii, rd_min_ii, rd_max_ii, CNT_W'(rd_outstanding)};
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            total++; if (got[i] !== e) begin bad++; $display("FAIL reset_%s got=%0h exp=%0h", rd_nm[i], got[i], e); end
        end
        reset = 1'b1;
        step(1);
    endtask

    // Ch0: S every 12 cycles, D 10 cycles after each start.
    task automatic test_ch0_interval();
        rd_sel = 2'd0;
        for (int k = 0; k < 36; k++) begin
            ap_start[0] = (k % 12 == 0);
            ap_ready[0] = (k % 12 == 0);
            ap_done[0]  = (k % 12 == 10);
            @(negedge clock);
            if (k == 0) begin
                total++; if (rd_outstanding !== 2'd1) begin bad++; $display("FAIL ch0_out_after_s got=%0d exp=1", rd_outstanding); end
                total++; if (ch_state[1:0] !== 2'd1) begin bad++; $display("FAIL ch0_busy got=%0d exp=1", ch_state[1:0]); end
                total++; if (all_idle !== 1'b1) begin bad++; $display("FAIL ch0_all_idle_lag got=%b exp=1", all_idle); end
            end
            if (k == 1) begin
                total++; if (all_idle !== 1'b0) begin bad++; $display("FAIL ch0_all_idle_low got=%b exp=0", all_idle); end
            end
        end
        idle_inputs();
        exp_q = '{16'd3, 16'd3, 16'd12, 16'd12, 16'd12, 16'd0};
        got = '{rd_start_cnt, rd_done_cnt, rd_last_ii, rd_min_ii, rd_max_ii, CNT_W'(rd_outstanding)};
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            total++; if (got[i] !== e) begin bad++; $display("FAIL ch0_%s got=%0d exp=%0d", rd_nm[i], got[i], e); end
        end
        total++; if (ch_state[1:0] !== 2'd0) begin bad++; $display("FAIL ch0_idle got=%0d exp=0", ch_state[1:0]); end
        total++; if (all_idle !== 1'b1) begin bad++; $display("FAIL ch0_all_idle_end got=%b exp=1", all_idle); end
    endtask

    // Ch1: two overlapping starts, then S and D together, then drain.
    task automatic test_overlap();
        rd_sel = 2'd1;
        pulse(1, 1'b1, 1'b0);
        total++; if (rd_outstanding !== 2'd1) begin bad++; $display("FAIL ch1_out1 got=%0d exp=1", rd_outstanding); end
        pulse(1, 1'b1, 1'b0);
        total++; if (rd_outstanding !== 2'd2) begin bad++; $display("FAIL ch1_out2 got=%0d exp=2", rd_outstanding); end
        pulse(1, 1'b1, 1'b1);
        total++; if (rd_outstanding !== 2'd2) begin bad++; $display("FAIL ch1_out_sd got=%0d exp=2", rd_outstanding); end
        total++; if (rd_start_cnt !== 16'd3) begin bad++; $display("FAIL ch1_start got=%0d exp=3", rd_start_cnt); end
        total++; if (rd_done_cnt !== 16'd1) begin bad++; $display("FAIL ch1_done got=%0d exp=1", rd_done_cnt); end
        total++; if (rd_min_ii !== 16'hFFFF) begin bad++; $display("FAIL ch1_min_one_done got=%0h exp=ffff", rd_min_ii); end
        pulse(1, 1'b0, 1'b1);
        pulse(1, 1'b0, 1'b1);
        exp_q = '{16'd3, 16'd3, 16'd1, 16'd1, 16'd1, 16'd0};
        got = '{rd_start_cnt, rd_done_cnt, rd_last_ii, rd_min_ii, rd_max_ii, CNT_W'(rd_outstanding)};
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            total++; if (got[i] !== e) begin bad++; $display("FAIL ch1_%s got=%0d exp=%0d", rd_nm[i], got[i], e); end
        end
        total++; if (ch_state[3:2] !== 2'd0) begin bad++; $display("FAIL ch1_idle got=%0d exp=0", ch_state[3:2]); end
    endtask

    // Ch2: done held without continue for 5 cycles.
    task automatic test_done_wait();
        rd_sel = 2'd2;
        pulse(2, 1'b1, 1'b0);
        total++; if (ch_state[5:4] !== 2'd1) begin bad++; $display("FAIL ch2_busy got=%0d exp=1", ch_state[5:4]); end
        for (int k = 0; k < 5; k++) begin
            ap_done[2]     = 1'b1;
            ap_continue[2] = 1'b0;
            @(negedge clock);
            total++; if (ch_state[5:4] !== 2'd2) begin bad++; $display("FAIL ch2_done_wait_%0d got=%0d exp=2", k, ch_state[5:4]); end
        end
        ap_continue[2] = 1'b1;
        @(negedge clock);
        total++; if (ch_state[5:4] !== 2'd0) begin bad++; $display("FAIL ch2_release got=%0d exp=0", ch_state[5:4]); end
        total++; if (rd_done_cnt !== 16'd1) begin bad++; $display("FAIL ch2_done got=%0d exp=1", rd_done_cnt); end
        ap_done[2] = 1'b0;
        @(negedge clock);
        total++; if (rd_done_cnt !== 16'd1) begin bad++; $display("FAIL ch2_done_hold got=%0d exp=1", rd_done_cnt); end
        total++; if (rd_outstanding !== 2'd0) begin bad++; $display("FAIL ch2_out got=%0d exp=0", rd_outstanding); end
    endtask

    // Done on an idle channel, and outstanding saturation.
    task automatic test_proto_sat();
        rd_sel = 2'd1;
        pulse(1, 1'b0, 1'b1);
        total++; if (proto_err !== 3'b010) begin bad++; $display("FAIL proto_idle_done got=%b exp=010", proto_err); end
        total++; if (rd_done_cnt !== 16'd3) begin bad++; $display("FAIL proto_done_cnt got=%0d exp=3", rd_done_cnt); end
        total++; if (rd_outstanding !== 2'd0) begin bad++; $display("FAIL proto_out got=%0d exp=0", rd_outstanding); end
        rd_sel = 2'd2;
        for (int k = 0; k < 3; k++) pulse(2, 1'b1, 1'b0);
        total++; if (rd_outstanding !== 2'd3) begin bad++; $display("FAIL sat_out_full got=%0d exp=3", rd_outstanding); end
        total++; if (proto_err[2] !== 1'b0) begin bad++; $display("FAIL sat_no_err got=%b exp=0", proto_err[2]); end
        pulse(2, 1'b1, 1'b0);
        total++; if (rd_outstanding !== 2'd3) begin bad++; $display("FAIL sat_out_hold got=%0d exp=3", rd_outstanding); end
        total++; if (proto_err !== 3'b110) begin bad++; $display("FAIL sat_err got=%b exp=110", proto_err); end
        total++; if (rd_start_cnt !== 16'd5) begin bad++; $display("FAIL sat_start got=%0d exp=5", rd_start_cnt); end
        for (int k = 0; k < 3; k++) pulse(2, 1'b0, 1'b1);
        total++; if (rd_outstanding !== 2'd0) begin bad++; $display("FAIL sat_drain_out got=%0d exp=0", rd_outstanding); end
        total++; if (rd_done_cnt !== 16'd4) begin bad++; $display("FAIL sat_drain_done got=%0d exp=4", rd_done_cnt); end
        total++; if (ch_state[5:4] !== 2'd0) begin bad++; $display("FAIL sat_idle got=%0d exp=0", ch_state[5:4]); end
    endtask

    // Ch0 start with no done until stall, then deadlock, then recovery.
    task automatic test_stall();
        rd_sel = 2'd0;
        pulse(0, 1'b1, 1'b0);
        for (int n = 1; n <= 17; n++) begin
            @(negedge clock);
            if (n == 15) begin
                total++; if (stall[0] !== 1'b0) begin bad++; $display("FAIL stall_early got=%b exp=0", stall[0]); end
            end
            if (n == 16) begin
                total++; if (stall[0] !== 1'b1) begin bad++; $display("FAIL stall_set got=%b exp=1", stall[0]); end
                total++; if (ch_state[1:0] !== 2'd3) begin bad++; $display("FAIL stall_state got=%0d exp=3", ch_state[1:0]); end
                total++; if (deadlock !== 1'b0) begin bad++; $display("FAIL deadlock_early got=%b exp=0", deadlock); end
            end
            if (n == 17) begin
                total++; if (deadlock !== 1'b1) begin bad++; $display("FAIL deadlock_set got=%b exp=1", deadlock); end
            end
        end
        pulse(0, 1'b0, 1'b1);
        total++; if (ch_state[1:0] !== 2'd0) begin bad++; $display("FAIL stall_recover got=%0d exp=0", ch_state[1:0]); end
        total++; if (stall !== 3'b001) begin bad++; $display("FAIL stall_sticky got=%b exp=001", stall); end
        total++; if (deadlock !== 1'b1) begin bad++; $display("FAIL deadlock_sticky got=%b exp=1", deadlock); end
        total++; if (rd_outstanding !== 2'd0) begin bad++; $display("FAIL stall_out got=%0d exp=0", rd_outstanding); end
    endtask

    // Reset asserted between edges while ch1 is busy.
    task automatic test_async_reset();
        rd_sel = 2'd1;
        pulse(1, 1'b1, 1'b0);
        total++; if (ch_state[3:2] !== 2'd1) begin bad++; $display("FAIL areset_pre_busy got=%0d exp=1", ch_state[3:2]); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (ch_state !== 6'b0) begin bad++; $display("FAIL areset_state got=%b exp=000000", ch_state); end
        total++; if (stall !== 3'b0) begin bad++; $display("FAIL areset_stall got=%b exp=000", stall); end
        total++; if (proto_err !== 3'b0) begin bad++; $display("FAIL areset_proto got=%b exp=000", proto_err); end
        total++; if (deadlock !== 1'b0) begin bad++; $display("FAIL areset_deadlock got=%b exp=0", deadlock); end
        total++; if (all_idle !== 1'b1) begin bad++; $display("FAIL areset_all_idle got=%b exp=1", all_idle); end
        exp_q = '{16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd0, 16'd0};
        got = '{rd_start_cnt, rd_done_cnt, rd_last_ii, rd_min_ii, rd_max_ii, CNT_W'(rd_outstanding)};
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            total++; if (got[i] !== e) begin bad++; $display("FAIL areset_%s got=%0h exp=%0h", rd_nm[i], got[i], e); end
        end
        @(negedge clock);
        reset = 1'b1;
        step(1);
    endtask

    // Freeze while ch0 is busy, then keep driving events.
    task automatic test_freeze();
        rd_sel = 2'd0;
        pulse(0, 1'b1, 1'b0);
        finish = 1'b1;
        @(negedge clock);
        pulse(0, 1'b1, 1'b0);
        pulse(0, 1'b0, 1'b1);
        pulse(0, 1'b1, 1'b1);
        pulse(1, 1'b0, 1'b1);
        step(20);
        exp_q = '{16'd1, 16'd0, 16'd0, 16'hFFFF, 16'd0, 16'd1};
        got = '{rd_start_cnt, rd_done_cnt, rd_last_ii, rd_min_ii, rd_max_ii, CNT_W'(rd_outstanding)};
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            total++; if (got[i] !== e) begin bad++; $display("FAIL freeze_%s got=%0h exp=%0h", rd_nm[i], got[i], e); end
        end
        total++; if (ch_state[1:0] !== 2'd1) begin bad++; $display("FAIL freeze_state got=%0d exp=1", ch_state[1:0]); end
        total++; if (stall !== 3'b0) begin bad++; $display("FAIL freeze_stall got=%b exp=000", stall); end
        total++; if (proto_err !== 3'b0) begin bad++; $display("FAIL freeze_proto got=%b exp=000", proto_err); end
        total++; if (deadlock !== 1'b0) begin bad++; $display("FAIL freeze_deadlock got=%b exp=0", deadlock); end
        total++; if (all_idle !== 1'b0) begin bad++; $display("FAIL freeze_all_idle got=%b exp=0", all_idle); end
        rd_sel = 2'd3;
        #1;
        exp_q = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        got = '{rd_start_cnt, rd_done_cnt, rd_last_ii, rd_min_ii, rd_max_ii, CNT_W'(rd_outstanding)};
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            total++; if (got[i] !== e) begin bad++; $display("FAIL oob_%s got=%0h exp=%0h", rd_nm[i], got[i], e); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        rd_sel = 2'd0;
        test_reset();
        test_ch0_interval();
        test_overlap();
        test_done_wait();
        test_proto_sat();
        test_stall();
        test_async_reset();
        test_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
